// File: rtl/ex_stage_pipe_if.sv
// ex_stage_pipe_if: handshake, operand and carried-field bundle between ID/EX and EX/MEM.
interface ex_stage_pipe_if #(
    parameter int WIDTH   = 32,
    parameter int INSTR_W = 32
);
    logic               in_valid, in_ready, flush, stall;
    logic [3:0]         ALUOP;
    logic [WIDTH-1:0]   operand1, operand2, regOut2In;
    logic [INSTR_W-1:0] instructionIn;
    logic               regdstIn, WBDataIn, branchIn, regWriteIn, dataMemWriteIn;
    logic               out_valid, zero, overflow, busy;
    logic [WIDTH-1:0]   out, regOut2;
    logic [INSTR_W-1:0] instructionMEMREAD;
    logic               regdst, WBData, branch, regWrite, dataMemWrite;

    modport master (
        output in_valid, flush, stall, ALUOP, operand1, operand2, regOut2In, instructionIn,
               regdstIn, WBDataIn, branchIn, regWriteIn, dataMemWriteIn,
        input  in_ready, out_valid, zero, overflow, busy, out, regOut2, instructionMEMREAD,
               regdst, WBData, branch, regWrite, dataMemWrite
    );
    modport slave (
        input  in_valid, flush, stall, ALUOP, operand1, operand2, regOut2In, instructionIn,
               regdstIn, WBDataIn, branchIn, regWriteIn, dataMemWriteIn,
        output in_ready, out_valid, zero, overflow, busy, out, regOut2, instructionMEMREAD,
               regdst, WBData, branch, regWrite, dataMemWrite
    );
endinterface

// File: rtl/ex_stage_pipe.sv
// ex_stage_pipe: execute stage with single-cycle ALU, iterative unsigned multiply and EX/MEM register.
module ex_stage_pipe #(
    parameter int WIDTH   = 32,
    parameter int INSTR_W = 32,
    parameter int SH_W    = $clog2(WIDTH)
) (
    input logic          clk,
    input logic          reset,
    ex_stage_pipe_if.slave bus
);
    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;
    state_t             state, state_nx;
    logic [SH_W-1:0]    cnt;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   a, b, ma, mb, m_reg2, res, mul_res, ld_out, ld_reg2;
    logic [INSTR_W-1:0] m_instr, ld_instr;
    logic [4:0]         m_ctrl, ld_ctrl;
    logic               m_hi, free, accept, is_mul, ovf, load_mul, load_single, ld;

    assign a           = bus.operand1;
    assign b           = bus.operand2;
    assign is_mul      = bus.ALUOP == 4'd10 || bus.ALUOP == 4'd11;
    assign free        = !bus.out_valid || !bus.stall;
    assign bus.in_ready = state == IDLE && free && !bus.flush;
    assign accept      = bus.in_valid && bus.in_ready;
    assign load_single = accept && !is_mul;
    assign load_mul    = state == DONE && free;
    assign ld          = load_single || load_mul;
    assign bus.busy    = state != IDLE;
    assign mul_res     = m_hi ? acc[2*WIDTH-1:WIDTH] : acc[WIDTH-1:0];

    always_comb begin
        res = '0;
        ovf = 1'b0;
        case (bus.ALUOP)
            4'd0: res = a & b;
            4'd1: res = a | b;
            4'd2: begin
                res = a + b;
                ovf = a[WIDTH-1] == b[WIDTH-1] && res[WIDTH-1] != a[WIDTH-1];
            end
            4'd3: res = a ^ b;
            4'd4: res = a << b[SH_W-1:0];
            4'd5: res = a >> b[SH_W-1:0];
            4'd6: begin
                res = a - b;
                ovf = a[WIDTH-1] != b[WIDTH-1] && res[WIDTH-1] != a[WIDTH-1];
            end
            4'd7: res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
            4'd8: res = $signed(a) >>> b[SH_W-1:0];
            4'd9: res = ~(a | b);
            default: res = '0;
        endcase
    end

    always_comb begin
        ld_out   = load_single ? res : mul_res;
        ld_reg2  = load_single ? bus.regOut2In : m_reg2;
        ld_instr = load_single ? bus.instructionIn : m_instr;
        ld_ctrl  = load_single ? {bus.regdstIn, bus.WBDataIn, bus.branchIn, bus.regWriteIn, bus.dataMemWriteIn} : m_ctrl;
        state_nx = bus.flush ? IDLE :
                   state == IDLE ? (accept && is_mul ? MUL : IDLE) :
                   state == MUL ? (cnt == SH_W'(WIDTH-1) ? DONE : MUL) :
                   (free ? IDLE : DONE);
    end

    always_ff @(posedge clk)
        state <= reset ? IDLE : state_nx;

    // Shift-add: bit cnt of the multiplier adds the multiplicand shifted into place.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt     <= '0;
            acc     <= '0;
            ma      <= '0;
            mb      <= '0;
            m_hi    <= 1'b0;
            m_reg2  <= '0;
            m_instr <= '0;
            m_ctrl  <= '0;
        end else if (accept && is_mul) begin
            cnt     <= '0;
            acc     <= '0;
            ma      <= a;
            mb      <= b;
            m_hi    <= bus.ALUOP[0];
            m_reg2  <= bus.regOut2In;
            m_instr <= bus.instructionIn;
            m_ctrl  <= {bus.regdstIn, bus.WBDataIn, bus.branchIn, bus.regWriteIn, bus.dataMemWriteIn};
        end else if (state == MUL) begin
            acc <= acc + (mb[cnt] ? {{WIDTH{1'b0}}, ma} << cnt : '0);
            cnt <= cnt + SH_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.out_valid          <= 1'b0;
            bus.out                <= '0;
            bus.zero               <= 1'b0;
            bus.overflow           <= 1'b0;
            bus.regOut2            <= '0;
            bus.instructionMEMREAD <= '0;
            {bus.regdst, bus.WBData, bus.branch, bus.regWrite, bus.dataMemWrite} <= '0;
        end else if (bus.flush) begin
            bus.out_valid <= 1'b0;
            {bus.branch, bus.regWrite, bus.dataMemWrite} <= '0;
        end else if (free) begin
            bus.out_valid <= ld;
            if (ld) begin
                bus.out                <= ld_out;
                bus.zero               <= ld_out == '0;
                bus.overflow           <= load_single && ovf;
                bus.regOut2            <= ld_reg2;
                bus.instructionMEMREAD <= ld_instr;
                {bus.regdst, bus.WBData, bus.branch, bus.regWrite, bus.dataMemWrite} <= ld_ctrl;
            end else begin
                {bus.branch, bus.regWrite, bus.dataMemWrite} <= '0;
            end
        end
    end
endmodule

// File: tb/tb_ex_stage_pipe.sv
// tb_ex_stage_pipe: scoreboard bench for ex_stage_pipe with directed and randomized traffic.
module tb_ex_stage_pipe;
    localparam int W  = 32;
    localparam int IW = 32;

    typedef struct packed {
        logic [W-1:0]  out;
        logic          zero, ovf;
        logic [W-1:0]  reg2;
        logic [IW-1:0] instr;
        logic [4:0]    ctrl;
    } exp_t;

    logic clk = 1'b0, reset = 1'b1;
    bit   rand_en = 1'b0;
    int   checks = 0, passes = 0, last_wait;
    exp_t q[$];

    always #5 clk = ~clk;

    ex_stage_pipe_if #(.WIDTH(W), .INSTR_W(IW)) bus();
    ex_stage_pipe #(.WIDTH(W), .INSTR_W(IW)) dut(.clk(clk), .reset(reset), .bus(bus));

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic [W-1:0] reg2, input logic [IW-1:0] instr, input logic [4:0] ctrl);
        exp_t          e;
        longint        sa = longint'($signed(a)), sb = longint'($signed(b)), s = 0, t;
        longint        lim = 64'sd1 <<< (W - 1);
        logic [2*W-1:0] p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        int            sh = int'(b[$clog2(W)-1:0]);
        logic [W-1:0]  r;
        logic          ov = 1'b0;
        case (op)
            4'd0: r = a & b;
            4'd1: r = a | b;
            4'd2: begin s = sa + sb; r = s[W-1:0]; ov = s >= lim || s < -lim; end
            4'd3: r = a ^ b;
            4'd4: r = a << sh;
            4'd5: r = a >> sh;
            4'd6: begin s = sa - sb; r = s[W-1:0]; ov = s >= lim || s < -lim; end
            4'd7: r = (sa < sb) ? W'(1) : W'(0);
            4'd8: begin t = sa >>> sh; r = t[W-1:0]; end
            4'd9: r = ~(a | b);
            4'd10: r = p[W-1:0];
            4'd11: r = p[2*W-1:W];
            default: r = '0;
        endcase
        e.out = r; e.zero = r == '0; e.ovf = ov; e.reg2 = reg2; e.instr = instr; e.ctrl = ctrl;
        return e;
    endfunction

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 4))
            0: return '0;
            1: return '1;
            2: return {1'b1, {(W-1){1'b0}}};
            3: return {1'b0, {(W-1){1'b1}}};
            default: return W'($urandom);
        endcase
    endfunction

    // Advance to just after the next rising edge; in random mode also re-roll stall.
    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_en) bus.stall = $urandom_range(0, 3) == 0;
    endtask

    task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input logic [4:0] ctrl);
        logic [W-1:0]  r2  = W'($urandom);
        logic [IW-1:0] ins = IW'($urandom);
        bus.ALUOP = op; bus.operand1 = a; bus.operand2 = b; bus.regOut2In = r2; bus.instructionIn = ins;
        {bus.regdstIn, bus.WBDataIn, bus.branchIn, bus.regWriteIn, bus.dataMemWriteIn} = ctrl;
        bus.in_valid = 1'b1;
        for (last_wait = 0; last_wait < 300; last_wait++) begin
            @(negedge clk);
            if (bus.in_ready) break;
            tick();
        end
        check("accept", 128'(last_wait < 300), 128'(1));
        if (last_wait < 300) q.push_back(model(op, a, b, r2, ins, ctrl));
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_out(output int e, output int bad);
        bad = 0;
        for (e = 0; e < 200; e++) begin
            @(negedge clk);
            if (bus.out_valid) break;
            if (!bus.busy || bus.in_ready) bad++;
            @(posedge clk);
        end
        check("out_timeout", 128'(e < 200), 128'(1));
    endtask

    // Monitor: a result is consumed on the edge after a negedge where it is valid and unstalled.
    always @(negedge clk) begin
        exp_t e, g;
        if (!reset) begin
            g = {bus.out, bus.zero, bus.overflow, bus.regOut2, bus.instructionMEMREAD,
                 bus.regdst, bus.WBData, bus.branch, bus.regWrite, bus.dataMemWrite};
            if (!bus.out_valid) check("bubble_ctrl", 128'({bus.branch, bus.regWrite, bus.dataMemWrite}), 128'(0));
            else if (!bus.stall && !bus.flush) begin
                if (q.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_output: got out=%h, expected no output", bus.out);
                end else begin
                    e = q.pop_front();
                    check("result", 128'(g), 128'(e));
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int e, bad, sum, sv;
        bus.in_valid = 0; bus.flush = 0; bus.stall = 0; bus.ALUOP = 0; bus.operand1 = 0; bus.operand2 = 0;
        bus.regOut2In = 0; bus.instructionIn = 0;
        {bus.regdstIn, bus.WBDataIn, bus.branchIn, bus.regWriteIn, bus.dataMemWriteIn} = 0;
        repeat (3) @(posedge clk);
        #1 reset = 0;
        @(negedge clk);
        check("reset_state", 128'({bus.out_valid, bus.out, bus.zero, bus.overflow, bus.busy, bus.regOut2,
              bus.instructionMEMREAD, bus.regdst, bus.WBData, bus.branch, bus.regWrite, bus.dataMemWrite}), 128'(0));
        check("reset_in_ready", 128'(bus.in_ready), 128'(1));
        tick();

        issue(4'd2, 32'h7FFF_FFFF, 32'h1, 5'b11111);
        @(negedge clk);
        check("add_ovf", 128'({bus.out_valid, bus.out, bus.overflow, bus.zero}), 128'({1'b1, 32'h8000_0000, 1'b1, 1'b0}));
        @(negedge clk);
        check("add_bubble", 128'({bus.out_valid, bus.regWrite}), 128'(0));
        tick();

        sum = 0;
        issue(4'd6, 32'd5, 32'd5, 5'b01010); sum += last_wait;
        issue(4'd7, 32'hFFFF_FFFF, 32'd1, 5'b00010); sum += last_wait;
        issue(4'd8, 32'h8000_0000, 32'd4, 5'b00010); sum += last_wait;
        check("back_to_back_waits", 128'(sum), 128'(0));
        @(negedge clk);
        check("sra", 128'({bus.out_valid, bus.out}), 128'({1'b1, 32'hF800_0000}));
        tick();

        issue(4'd10, 32'hFFFF_FFFF, 32'd2, 5'b01010);
        wait_out(e, bad);
        check("mul_latency", 128'(e), 128'(W + 1));
        check("mul_busy_not_ready", 128'(bad), 128'(0));
        check("mul_low", 128'(bus.out), 128'(32'hFFFF_FFFE));
        tick();
        issue(4'd11, 32'hFFFF_FFFF, 32'd2, 5'b01010);
        wait_out(e, bad);
        check("mulhu", 128'({bus.out, bus.zero}), 128'({32'h1, 1'b0}));
        tick();

        issue(4'd0, 32'hF0F0_F0F0, 32'h3C3C_3C3C, 5'b00110);
        bus.stall = 1;
        repeat (3) begin
            @(negedge clk);
            check("stall_hold", 128'({bus.out_valid, bus.out, bus.in_ready}), 128'({1'b1, 32'h3030_3030, 1'b0}));
            tick();
        end
        bus.stall = 0;
        issue(4'd1, 32'h1, 32'h2, 5'b00010);
        check("accept_after_stall", 128'(last_wait), 128'(0));

        issue(4'd10, pick(), W'($urandom), 5'b00010);
        repeat (20) @(posedge clk);
        #1 bus.stall = 1;
        wait_out(e, bad);
        repeat (2) begin
            tick();
            @(negedge clk);
            check("mul_stall_hold", 128'({bus.out_valid, bus.busy, bus.in_ready}), 128'({1'b1, 1'b0, 1'b0}));
        end
        tick();
        bus.stall = 0;

        issue(4'd10, 32'h1234_5678, 32'h9ABC_DEF0, 5'b00010);
        repeat (9) @(posedge clk);
        #1 bus.flush = 1;
        void'(q.pop_back());
        tick();
        bus.flush = 0;
        @(negedge clk);
        check("flush_mul", 128'({bus.busy, bus.out_valid}), 128'(0));
        sv = 0;
        repeat (40) begin
            @(negedge clk);
            sv += int'(bus.out_valid);
        end
        check("flush_no_result", 128'(sv), 128'(0));
        tick();

        issue(4'd2, 32'd3, 32'd4, 5'b11111);
        bus.stall = 1;
        @(negedge clk);
        check("pre_flush_valid", 128'(bus.out_valid), 128'(1));
        tick();
        bus.flush = 1;
        void'(q.pop_front());
        tick();
        bus.flush = 0;
        @(negedge clk);
        check("flush_stalled", 128'({bus.out_valid, bus.regWrite, bus.branch, bus.dataMemWrite}), 128'(0));
        tick();
        bus.stall = 0;

        issue(4'd11, pick(), pick(), 5'b11111);
        repeat (5) @(posedge clk);
        #1 reset = 1;
        void'(q.pop_back());
        tick();
        reset = 0;
        @(negedge clk);
        check("reset_mid_mul", 128'({bus.out_valid, bus.out, bus.zero, bus.overflow, bus.busy, bus.regOut2,
              bus.instructionMEMREAD, bus.regdst, bus.WBData, bus.branch, bus.regWrite, bus.dataMemWrite}), 128'(0));
        check("reset_mid_mul_ready", 128'(bus.in_ready), 128'(1));
        tick();

        rand_en = 1;
        repeat (200) begin
            repeat ($urandom_range(0, 2)) tick();
            issue(4'($urandom_range(0, 15)), pick(), pick(), 5'($urandom));
        end
        rand_en = 0;
        bus.stall = 0;
        for (int i = 0; i < 2000 && q.size() != 0; i++) @(negedge clk);
        check("drain", 128'(q.size()), 128'(0));
        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/ex_stage_pipe.md
Name: ex_stage_pipe

Overview:
- Parametrised execute stage with a registered EX/MEM pipeline register, replacing the combinational pass-through execute stage.
- Performs single-cycle ALU operations and an iterative multi-cycle unsigned multiply.
- Supports valid/ready input handshake, downstream stall, and flush.
- Carries instruction word, store data and control bits alongside the result into the MEM stage.

Parameters:
- WIDTH, 32, datapath width for operands, result and store data (>= 8).
- INSTR_W, 32, width of the carried instruction word.
- SH_W, $clog2(WIDTH), shift-amount bits taken from operand2 (derived; do not override).

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream presents an instruction.
- in_ready  output  1  stage can accept this cycle (combinational).
- flush  input  1  discard the in-flight instruction and output-register contents.
- stall  input  1  MEM stage cannot take output; output register holds.
- ALUOP  input  4  operation select.
- operand1  input  WIDTH  A operand.
- operand2  input  WIDTH  B operand.
- instructionIn  input  INSTR_W  carried instruction word.
- regOut2In  input  WIDTH  carried store data.
- regdstIn, WBDataIn, branchIn, regWriteIn, dataMemWriteIn  input  1 each  carried control bits.
- out_valid  output  1  output register holds a valid instruction.
- out  output  WIDTH  registered result.
- zero  output  1  registered (result == 0).
- overflow  output  1  registered signed overflow (ADD/SUB only, else 0).
- busy  output  1  multiply in progress (state != IDLE).
- regOut2  output  WIDTH  registered store data.
- instructionMEMREAD  output  INSTR_W  registered instruction word.
- regdst, WBData, branch, regWrite, dataMemWrite  output  1 each  registered control bits.

Behaviour:
- Reset (clk edge with reset=1): every output register = 0, out_valid = 0, state = IDLE, multiply counter and accumulator = 0. Reset overrides flush and stall.
- Output-register free condition: free = !out_valid || !stall.
- in_ready = (state == IDLE) && free && !flush.
- An instruction is accepted on an edge where in_valid && in_ready.
- ALUOP encoding (shifts use operand2[SH_W-1:0]; SLT is signed):
  - 0 AND, 1 OR, 2 ADD, 3 XOR, 4 SLL, 5 SRL, 6 SUB, 7 SLT, 8 SRA, 9 NOR.
  - 10 MUL: low WIDTH bits of the unsigned product.
  - 11 MULHU: high WIDTH bits of the unsigned product.
  - 12-15: result 0, accepted as a normal single-cycle op.
- Single-cycle op: accepted at edge N. out, zero, overflow, carried fields and out_valid=1 are loaded at edge N, so they are visible in the cycle after N. Latency is 1.
- Overflow is computed only for ADD and SUB:
  - ADD: operands share a sign and the result sign differs.
  - SUB: operand signs differ and the result sign differs from operand1.
- Multiply FSM:
  - IDLE -> MUL on accepting op 10/11. Operands, op, and all carried fields are latched; counter = 0.
  - MUL: shift-add, one bit per cycle, for WIDTH cycles. Goes to DONE on the edge where counter reaches WIDTH-1.
  - DONE: when free, loads the output register (out_valid=1) and returns to IDLE. Otherwise stays in DONE.
  - Unstalled latency: WIDTH+1 edges from accept to out_valid. in_ready stays 0 throughout.
  - zero reflects the selected half of the product; overflow = 0.
- Stall: while stall && out_valid, all output registers hold. A multiply continues computing and waits in DONE.
- When free and nothing is loaded: out_valid <= 0; branch, regWrite, dataMemWrite <= 0 (bubble); data fields hold their values.
- Flush (reset=0):
  - out_valid <= 0 and the three side-effect control bits <= 0, regardless of stall.
  - The FSM returns to IDLE, aborting any multiply.
  - A same-cycle in_valid is not accepted.
- out_valid=0 guarantees regWrite=dataMemWrite=branch=0.

Test Plan:
- ADD: 0x7FFFFFFF + 0x00000001, in_valid for 1 cycle -> next cycle out=0x80000000, overflow=1, zero=0, out_valid=1. Following cycle out_valid=0, regWrite=0.
- SUB/SLT/SRA: 5 - 5 -> out=0, zero=1. SLT 0xFFFFFFFF, 1 -> out=1. SRA 0x80000000 by 4 -> 0xF8000000. Back-to-back ops every cycle with stall=0 -> one result per cycle, in order.
- MUL: 0xFFFFFFFF * 0x00000002 with op 10 -> out=0xFFFFFFFE exactly 33 edges after accept; in_ready=0 and busy=1 meanwhile. MULHU on the same operands -> out=0x00000001.
- Stall: single-cycle op followed by stall=1 for 3 cycles -> outputs and out_valid held, in_ready=0. New op accepted on the first cycle stall=0.
- Multiply finishing during stall: product held in DONE. It is loaded on the edge stall drops (the previous valid output leaves on that edge).
- Flush: flush pulsed mid-multiply (cycle 10) -> busy=0 and out_valid=0 next cycle, no result ever appears. Flush with stall=1 and out_valid=1 -> out_valid=0, regWrite=0 next cycle. Reset mid-multiply -> all outputs 0, state IDLE.
